// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcode, funct-field and operation encodings, plus the
// decoded_instr_t record produced by instr_decoder and queued by decode_queue.
package riscv_pkg;

   typedef enum logic [6:0] {
      OPC_LOAD     = 7'b0000011,
      OPC_MISC_MEM = 7'b0001111,
      OPC_ALU_IMM  = 7'b0010011,
      OPC_AUIPC    = 7'b0010111,
      OPC_STORE    = 7'b0100011,
      OPC_ALU      = 7'b0110011,
      OPC_LUI      = 7'b0110111,
      OPC_BRANCH   = 7'b1100011,
      OPC_JALR     = 7'b1100111,
      OPC_JAL      = 7'b1101111,
      OPC_MISC     = 7'b1110011
   } opcode_t;

   // Code 0 doubles as the "no operation" value carried by illegal records.
   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_SLL    = 5'd2,
      OP_SLT    = 5'd3,
      OP_SLTU   = 5'd4,
      OP_XOR    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_OR     = 5'd8,
      OP_AND    = 5'd9,
      OP_BEQ    = 5'd10,
      OP_BNE    = 5'd11,
      OP_BLT    = 5'd12,
      OP_BGE    = 5'd13,
      OP_BLTU   = 5'd14,
      OP_BGEU   = 5'd15,
      OP_LUI    = 5'd16,
      OP_AUIPC  = 5'd17,
      OP_JAL    = 5'd18,
      OP_JALR   = 5'd19,
      OP_LOAD   = 5'd20,
      OP_STORE  = 5'd21,
      OP_FENCE  = 5'd22,
      OP_ECALL  = 5'd23,
      OP_EBREAK = 5'd24,
      OP_CSRRW  = 5'd25,
      OP_CSRRS  = 5'd26,
      OP_CSRRC  = 5'd27
   } operation_t;

   typedef enum logic [2:0] {
      F3_ADD_SUB = 3'd0,
      F3_SLL     = 3'd1,
      F3_SLT     = 3'd2,
      F3_SLTU    = 3'd3,
      F3_XOR     = 3'd4,
      F3_SRL_SRA = 3'd5,
      F3_OR      = 3'd6,
      F3_AND     = 3'd7
   } funct3_alu_t;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'd0,
      F3_BNE  = 3'd1,
      F3_BLT  = 3'd4,
      F3_BGE  = 3'd5,
      F3_BLTU = 3'd6,
      F3_BGEU = 3'd7
   } funct3_branch_t;

   typedef enum logic [2:0] {
      F3_PRIV   = 3'd0,
      F3_CSRRW  = 3'd1,
      F3_CSRRS  = 3'd2,
      F3_CSRRC  = 3'd3,
      F3_CSRRWI = 3'd5,
      F3_CSRRSI = 3'd6,
      F3_CSRRCI = 3'd7
   } funct3_sys_t;

   typedef enum logic [6:0] {
      F7_BASE = 7'b0000000,
      F7_ALT  = 7'b0100000
   } funct7_t;

   typedef enum logic [11:0] {
      F12_ECALL  = 12'h000,
      F12_EBREAK = 12'h001
   } funct12_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      operation_t  op;
      logic [31:0] imm;
      logic        illegal;
   } decoded_instr_t;

   // ALU operation for register and immediate forms; alt selects SUB/SRA.
   function automatic operation_t alu_op(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD_SUB: return alt ? OP_SUB : OP_ADD;
         F3_SLL:     return OP_SLL;
         F3_SLT:     return OP_SLT;
         F3_SLTU:    return OP_SLTU;
         F3_XOR:     return OP_XOR;
         F3_SRL_SRA: return alt ? OP_SRA : OP_SRL;
         F3_OR:      return OP_OR;
         default:    return OP_AND;
      endcase
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational RV32I decoder.
// Ports:
//   instr  - instruction word
//   pc     - PC of instr, carried into the record
//   dec    - decoded record (fields, operation, sign-extended immediate, illegal flag)
// CHECK_ILLEGAL = 0 forces dec.illegal low and leaves the operation as decoded.
module instr_decoder
   import riscv_pkg::*;
#(
   parameter bit CHECK_ILLEGAL = 1'b1
) (
   input  logic [31:0]    instr,
   input  logic [31:0]    pc,
   output decoded_instr_t dec
);

   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [11:0] f12;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        f7_ok_alt;
   logic        f7_zero;
   operation_t  op;
   logic [31:0] imm;
   logic        bad;
   logic        illegal;

   assign f3  = instr[14:12];
   assign f7  = instr[31:25];
   assign f12 = instr[31:20];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'h000};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   assign f7_ok_alt = (f7 == F7_BASE) || (f7 == F7_ALT);
   assign f7_zero   = (f7 == F7_BASE);

   always_comb begin
      op  = OP_ADD;
      imm = 32'h0;
      bad = 1'b0;
      case (instr[6:0])
         OPC_LOAD: begin
            imm = imm_i;
            op  = OP_LOAD;
            bad = (f3 == 3'd3) || (f3 >= 3'd6);
         end
         OPC_STORE: begin
            imm = imm_s;
            op  = OP_STORE;
            bad = (f3 > 3'd2);
         end
         OPC_BRANCH: begin
            imm = imm_b;
            case (f3)
               F3_BEQ:  op = OP_BEQ;
               F3_BNE:  op = OP_BNE;
               F3_BLT:  op = OP_BLT;
               F3_BGE:  op = OP_BGE;
               F3_BLTU: op = OP_BLTU;
               F3_BGEU: op = OP_BGEU;
               default: bad = 1'b1;
            endcase
         end
         OPC_LUI: begin
            imm = imm_u;
            op  = OP_LUI;
         end
         OPC_AUIPC: begin
            imm = imm_u;
            op  = OP_AUIPC;
         end
         OPC_JAL: begin
            imm = imm_j;
            op  = OP_JAL;
         end
         OPC_JALR: begin
            imm = imm_i;
            op  = OP_JALR;
         end
         OPC_MISC_MEM: begin
            imm = imm_i;
            op  = OP_FENCE;
            bad = (f3 > 3'd1);  // FENCE and FENCE.I only
         end
         OPC_MISC: begin
            imm = imm_i;
            case (f3)
               F3_PRIV: begin
                  if (f12 == F12_ECALL)       op = OP_ECALL;
                  else if (f12 == F12_EBREAK) op = OP_EBREAK;
                  else                        bad = 1'b1;
               end
               F3_CSRRW, F3_CSRRWI: op = OP_CSRRW;
               F3_CSRRS, F3_CSRRSI: op = OP_CSRRS;
               F3_CSRRC, F3_CSRRCI: op = OP_CSRRC;
               default:             bad = 1'b1;
            endcase
         end
         OPC_ALU_IMM: begin
            imm = imm_i;
            // No SUBI: instr[30] only selects SRAI.
            op  = alu_op(f3, (f3 == F3_SRL_SRA) && instr[30]);
            if (f3 == F3_SLL)          bad = !f7_zero;
            else if (f3 == F3_SRL_SRA) bad = !f7_ok_alt;
         end
         OPC_ALU: begin
            op = alu_op(f3, instr[30]);
            if ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)) bad = !f7_ok_alt;
            else                                          bad = !f7_zero;
         end
         default: bad = 1'b1;
      endcase
      if (instr[1:0] != 2'b11) bad = 1'b1;

      illegal = CHECK_ILLEGAL && bad;
      if (illegal) op = OP_ADD;  // illegal records carry operation code 0

      dec.instr   = instr;
      dec.pc      = pc;
      dec.rs1     = instr[19:15];
      dec.rs2     = instr[24:20];
      dec.rd      = instr[11:7];
      dec.op      = op;
      dec.imm     = imm;
      dec.illegal = illegal;
   end

endmodule

// File: rtl/decode_queue.sv
// Buffered decode stage: decodes fetched RV32I beats and queues the records in a
// DEPTH-entry FIFO so no combinational path crosses from fetch to execute.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - drop all queued records and the current input beat
//   t_instr, t_pc, t_instr_valid / t_instr_ready - fetch side handshake
//   i_instr, i_pc, i_rs1, i_rs2, i_rd, i_op, i_imm, i_illegal - head record
//   i_instr_valid / i_instr_ready - execute side handshake
//   occupancy           - number of queued records
module decode_queue
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH         = 2,
   parameter bit          CHECK_ILLEGAL = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic [31:0]              t_instr,
   input  logic [31:0]              t_pc,
   input  logic                     t_instr_valid,
   output logic                     t_instr_ready,
   output logic [31:0]              i_instr,
   output logic [31:0]              i_pc,
   output logic [4:0]               i_rs1,
   output logic [4:0]               i_rs2,
   output logic [4:0]               i_rd,
   output logic [4:0]               i_op,
   output logic [31:0]              i_imm,
   output logic                     i_illegal,
   output logic                     i_instr_valid,
   input  logic                     i_instr_ready,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned OccW = PtrW + 1;

   decoded_instr_t      mem_q [DEPTH];
   decoded_instr_t      dec;
   decoded_instr_t      head;
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [OccW-1:0]     occ_q;
   logic                push, pop;

   instr_decoder #(
      .CHECK_ILLEGAL (CHECK_ILLEGAL)
   ) u_decoder (
      .instr (t_instr),
      .pc    (t_pc),
      .dec   (dec)
   );

   // Ready depends only on registered occupancy: a pop in the full cycle does not
   // open it, keeping i_instr_ready off the fetch-side timing path.
   assign t_instr_ready = !rst && !flush && (occ_q < OccW'(DEPTH));
   assign i_instr_valid = (occ_q != '0);
   assign push          = t_instr_valid && t_instr_ready;
   assign pop           = i_instr_valid && i_instr_ready && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= dec;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (push && !pop) begin
            occ_q <= occ_q + OccW'(1);
         end else if (pop && !push) begin
            occ_q <= occ_q - OccW'(1);
         end
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign i_instr   = head.instr;
   assign i_pc      = head.pc;
   assign i_rs1     = head.rs1;
   assign i_rs2     = head.rs2;
   assign i_rd      = head.rd;
   assign i_op      = head.op;
   assign i_imm     = head.imm;
   assign i_illegal = head.illegal;
   assign occupancy = occ_q;

endmodule
